// File: rtl/pool_pingpong_buffer.sv
// pool_pingpong_buffer
//
// Collects the raster-ordered output stream of the 2x2 max-pooling stage into
// one of two frame banks. Each bank holds OUT_SIZE*OUT_SIZE words. Once a bank
// is complete, the next layer reads it through a registered random-access
// port. The other bank keeps filling with the next frame in the meantime.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   in_valid     in_data carries a pooled value this cycle
//   in_data      pooled value, row-major order
//   in_ready     the current write bank can accept a word
//   frame_ready  the read bank holds a complete frame
//   rd_en        read request
//   rd_addr      word address in the read bank (row*OUT_SIZE+col)
//   rd_data      registered read data
//   rd_valid     rd_data is valid this cycle
//   rd_release   consumer is done with the read bank; frees it
//   frame_count  number of completed frames written, wraps 255->0
//   overflow     sticky; set when in_valid arrives while in_ready=0
//
// Write handshake: a word transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready depends only on registers, never on in_valid.
// A word offered while in_ready=0 is dropped rather than stalled, and it sets
// overflow.

module pool_pingpong_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_SIZE   = 128,
  localparam int DEPTH     = OUT_SIZE * OUT_SIZE,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  frame_ready,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_release,
  output logic [7:0]            frame_count,
  output logic                  overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];

  logic [1:0]        full;
  logic              wb;
  logic              rb;
  logic [ADDR_W-1:0] wcnt;

  logic       wr_fire;
  logic       wr_last;
  logic       rel_fire;
  logic [1:0] full_set;
  logic [1:0] full_clr;

  assign in_ready    = ~full[wb];
  assign frame_ready = full[rb];

  // Writes are also blocked during the reset cycle, so a beat offered while
  // reset is high never lands in memory.
  assign wr_fire  = in_valid & in_ready & ~reset;
  assign wr_last  = wr_fire & (wcnt == LAST_ADDR);
  assign rel_fire = rd_release & full[rb];

  // The bank being completed and the bank being released are always
  // different: when wb==rb and that bank is full, in_ready is low. So a set
  // and a clear in the same cycle never touch the same bit.
  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    if (wr_last)  full_set[wb] = 1'b1;
    if (rel_fire) full_clr[rb] = 1'b1;
  end

  // Bank bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      full        <= 2'b00;
      wb          <= 1'b0;
      rb          <= 1'b0;
      wcnt        <= '0;
      frame_count <= 8'd0;
      overflow    <= 1'b0;
    end else begin
      full <= (full | full_set) & ~full_clr;

      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end

      if (wr_fire) begin
        if (wr_last) begin
          wcnt        <= '0;
          wb          <= ~wb;
          frame_count <= frame_count + 8'd1;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end

      if (rel_fire) begin
        rb <= ~rb;
      end
    end
  end

  // Frame storage. The memory is not reset, so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wb) begin
        mem1[wcnt] <= in_data;
      end else begin
        mem0[wcnt] <= in_data;
      end
    end
  end

  // Registered read port. A read in the same cycle as a release is served
  // from the bank being released, because rb only changes at this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_en && full[rb]) begin
        rd_data  <= rb ? mem1[rd_addr] : mem0[rd_addr];
        rd_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pool_pingpong_buffer.sv
// tb_pool_pingpong_buffer
//
// Directed bench for pool_pingpong_buffer with OUT_SIZE=4 (16 words/bank).
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// at the same point, i.e. after the registers have updated for that edge.

module tb_pool_pingpong_buffer;

  localparam int DW     = 16;
  localparam int OS     = 4;
  localparam int DEPTH  = OS * OS;
  localparam int AW     = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          frame_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_release;
  logic [7:0]    frame_count;
  logic          overflow;

  pool_pingpong_buffer #(.DATA_WIDTH(DW), .OUT_SIZE(OS)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .frame_ready (frame_ready),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_release  (rd_release),
    .frame_count (frame_count),
    .overflow    (overflow)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [3][DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_beat(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic do_release();
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en   = 1'b0;
    check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    in_valid   = 1'b0;
    in_data    = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    rd_release = 1'b0;
    reset      = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_frame_ready", 32'(frame_ready), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_frame_count", 32'(frame_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);

    // One back-to-back frame, then back-to-back reads
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("t1_in_ready", 32'(in_ready), 32'd1);
      if (i == DEPTH - 1) check_eq("t1_not_ready_early", 32'(frame_ready), 32'd0);
      write_beat(DW'(i));
    end
    check_eq("t1_frame_ready", 32'(frame_ready), 32'd1);
    check_eq("t1_frame_count", 32'(frame_count), 32'd1);
    check_eq("t1_in_ready_after", 32'(in_ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      rd_en   = 1'b1;
      rd_addr = AW'(i);
      exp_q.push_back(DW'(i));
      step();
      check_eq("t1_rd_valid", 32'(rd_valid), 32'd1);
      check_eq("t1_rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
    rd_en = 1'b0;
    step();
    check_eq("t1_rd_valid_idle", 32'(rd_valid), 32'd0);
    do_release();
    check_eq("t1_released", 32'(frame_ready), 32'd0);

    // Both banks full, overflow, release
    for (int i = 0; i < DEPTH; i++) write_beat(16'h0100 + DW'(i));
    check_eq("t2_a_ready", 32'(frame_ready), 32'd1);
    check_eq("t2_in_ready_mid", 32'(in_ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) write_beat(16'h0200 + DW'(i));
    check_eq("t2_in_ready_full", 32'(in_ready), 32'd0);
    check_eq("t2_frame_count", 32'(frame_count), 32'd3);
    check_eq("t2_no_overflow_yet", 32'(overflow), 32'd0);
    write_beat(16'hDEAD);
    check_eq("t2_overflow", 32'(overflow), 32'd1);
    check_eq("t2_count_after_drop", 32'(frame_count), 32'd3);
    do_read("t2_rd_a5", 4'd5, 16'h0105);
    do_release();
    check_eq("t2_frame_ready_b", 32'(frame_ready), 32'd1);
    check_eq("t2_in_ready_freed", 32'(in_ready), 32'd1);
    do_read("t2_rd_b5", 4'd5, 16'h0205);
    do_read("t2_rd_b0", 4'd0, 16'h0200);
    check_eq("t2_overflow_sticky", 32'(overflow), 32'd1);

    // Last write beat coincides with release of the other bank
    do_reset();
    check_eq("t3_overflow_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) write_beat(16'h0300 + DW'(i));
    for (int i = 0; i < DEPTH - 1; i++) write_beat(16'h0400 + DW'(i));
    in_valid   = 1'b1;
    in_data    = 16'h040F;
    rd_release = 1'b1;
    step();
    in_valid   = 1'b0;
    rd_release = 1'b0;
    check_eq("t3_frame_ready", 32'(frame_ready), 32'd1);
    check_eq("t3_frame_count", 32'(frame_count), 32'd2);
    check_eq("t3_in_ready", 32'(in_ready), 32'd1);
    do_read("t3_rd_b15", 4'd15, 16'h040F);
    do_read("t3_rd_b0", 4'd0, 16'h0400);
    do_release();
    check_eq("t3_released", 32'(frame_ready), 32'd0);

    // Read and release with no frame ready
    rd_en      = 1'b1;
    rd_addr    = 4'd3;
    rd_release = 1'b1;
    step();
    rd_en      = 1'b0;
    rd_release = 1'b0;
    check_eq("t4_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("t4_rd_data_hold", 32'(rd_data), 32'h0400);
    check_eq("t4_frame_ready", 32'(frame_ready), 32'd0);
    // rb must still point at bank 0, which is the next bank written
    for (int i = 0; i < DEPTH; i++) write_beat(16'h0600 + DW'(i));
    check_eq("t4_rb_unchanged", 32'(frame_ready), 32'd1);
    do_read("t4_rd_7", 4'd7, 16'h0607);

    // Three frames with random input gaps, reads between frames
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        model[f][i] = 16'h1000 + DW'(f * 256) + DW'(i * 7);
        while ($urandom_range(1, 0) == 0) step();
        write_beat(model[f][i]);
      end
      check_eq("t5_frame_ready", 32'(frame_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
        int a;
        a = $urandom_range(DEPTH - 1, 0);
        do_read("t5_rd", AW'(a), model[f][a]);
      end
      do_release();
    end
    check_eq("t5_overflow", 32'(overflow), 32'd0);
    check_eq("t5_frame_count", 32'(frame_count), 32'd3);

    // Reset mid-frame while a frame is ready and a read is in flight
    for (int i = 0; i < DEPTH; i++) write_beat(16'h0700 + DW'(i));
    for (int i = 0; i < 6; i++) write_beat(16'h0800 + DW'(i));
    rd_en   = 1'b1;
    rd_addr = 4'd1;
    write_beat(16'h0806);
    rd_en = 1'b0;
    check_eq("t6_pre_rd_valid", 32'(rd_valid), 32'd1);
    check_eq("t6_pre_frame_ready", 32'(frame_ready), 32'd1);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    check_eq("t6_frame_count", 32'(frame_count), 32'd0);
    check_eq("t6_overflow", 32'(overflow), 32'd0);
    check_eq("t6_frame_ready", 32'(frame_ready), 32'd0);
    check_eq("t6_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("t6_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) write_beat(16'h0500 + DW'(i));
    check_eq("t6_refill_ready", 32'(frame_ready), 32'd1);
    check_eq("t6_refill_count", 32'(frame_count), 32'd1);
    do_read("t6_rd_0", 4'd0, 16'h0500);
    do_read("t6_rd_6", 4'd6, 16'h0506);
    do_read("t6_rd_15", 4'd15, 16'h050F);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
